// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel row window block.
package pixel_pkg;

    // Occupancy states of the window controller
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } fill_state_t;

    // Output layout selection
    localparam logic MODE_ROW       = 1'b0;
    localparam logic MODE_TRANSPOSE = 1'b1;

    // Occupancy state implied by a fill level
    function automatic fill_state_t state_for(input logic is_zero, input logic is_full);
        if (is_zero)
            return ST_EMPTY;
        else if (is_full)
            return ST_FULL;
        else
            return ST_FILL;
    endfunction

endpackage

// File: rtl/window_layout.sv
// Combinational mapping of the row slots onto the output window bus,
// either row-major or transposed (column-major).
module window_layout
    import pixel_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 8,
    parameter int DEPTH   = 15
) (
    input  logic                             mode,
    input  logic [DEPTH*ROW_PIX*PIX_W-1:0]   slots_flat,
    output logic [DEPTH*ROW_PIX*PIX_W-1:0]   win
);

    // Place slot r pixel k according to the selected layout
    always_comb begin
        win = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            for (int unsigned k = 0; k < ROW_PIX; k++) begin
                if (mode == MODE_TRANSPOSE)
                    win[(k*DEPTH + r)*PIX_W +: PIX_W] = slots_flat[(r*ROW_PIX + k)*PIX_W +: PIX_W];
                else
                    win[(r*ROW_PIX + k)*PIX_W +: PIX_W] = slots_flat[(r*ROW_PIX + k)*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/pixel_row_window.sv
// Sliding window of the DEPTH most recent pixel rows. Rows shift in at the
// top slot; a consume releases STEP rows while keeping the newest ones as the
// head of the next window. The output bus is registered and laid out per the
// mode latched at the first row of a window.
module pixel_row_window
    import pixel_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int ROW_PIX = 8,
    parameter int DEPTH   = 15,
    parameter int STEP    = 8
) (
    input  logic                                 clock,
    input  logic                                 reset_L,
    input  logic                                 clear_L,
    input  logic                                 mode,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ROW_PIX*PIX_W-1:0]             in_row,
    output logic                                 win_valid,
    input  logic                                 win_ready,
    output logic [DEPTH*ROW_PIX*PIX_W-1:0]       win,
    output logic [$clog2(DEPTH+1)-1:0]           fill_cnt
);

    localparam int ROW_W = ROW_PIX * PIX_W;
    localparam int WIN_W = DEPTH * ROW_W;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW:0]   STEP_W  = (CW+1)'(STEP);

    logic [ROW_W-1:0] slots     [DEPTH];
    logic [ROW_W-1:0] slots_nxt [DEPTH];
    logic [WIN_W-1:0] slots_nxt_flat;
    logic [WIN_W-1:0] win_nxt;

    fill_state_t      state;
    logic             run;
    logic             mode_q;
    logic             mode_nxt;
    logic             accept;
    logic             consume;
    logic [CW-1:0]    fill_nxt;
    logic [CW:0]      fill_sum;

    assign win_valid = (state == ST_FULL);
    assign consume   = win_valid && win_ready;
    // run holds in_ready low until the first edge after reset release
    assign in_ready  = run && clear_L && ((fill_cnt < DEPTH_C) || consume);
    assign accept    = in_valid && in_ready;

    // Next fill level: add the accepted row, release STEP on consume, clamp to 0..DEPTH
    always_comb begin
        fill_sum = {1'b0, fill_cnt} + {{CW{1'b0}}, accept};
        if (consume)
            fill_sum = (fill_sum > STEP_W) ? (fill_sum - STEP_W) : '0;
        if (fill_sum > DEPTH_W)
            fill_sum = DEPTH_W;
        fill_nxt = fill_sum[CW-1:0];
    end

    // Next slot contents and layout mode for an accept
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++)
            slots_nxt[i] = slots[i];
        if (accept) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++)
                slots_nxt[i] = slots[i+1];
            slots_nxt[DEPTH-1] = in_row;
        end
        mode_nxt = (accept && (fill_cnt == '0)) ? mode : mode_q;
    end

    // Flatten next slots for the layout mapper
    always_comb begin
        slots_nxt_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            slots_nxt_flat[i*ROW_W +: ROW_W] = slots_nxt[i];
    end

    // Layout is computed from the post-accept slots so win lands on the accept edge
    window_layout #(
        .PIX_W   (PIX_W),
        .ROW_PIX (ROW_PIX),
        .DEPTH   (DEPTH)
    ) u_layout (
        .mode       (mode_nxt),
        .slots_flat (slots_nxt_flat),
        .win        (win_nxt)
    );

    // Control FSM: occupancy state, fill level, ready enable and latched mode
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ST_EMPTY;
            fill_cnt <= '0;
            run      <= 1'b0;
            mode_q   <= MODE_ROW;
        end else begin
            run <= 1'b1;
            if (!clear_L) begin
                state    <= ST_EMPTY;
                fill_cnt <= '0;
            end else begin
                state    <= state_for(fill_nxt == '0, fill_nxt == DEPTH_C);
                fill_cnt <= fill_nxt;
                mode_q   <= mode_nxt;
            end
        end
    end

    // Row storage and registered window output
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                slots[i] <= '0;
            win <= '0;
        end else if (!clear_L) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                slots[i] <= '0;
            win <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                slots[i] <= slots_nxt[i];
            win <= win_nxt;
        end
    end

endmodule
